// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    localparam int RAM_AW = 12;
    localparam int RAM_DW = 4;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module ram_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    logic found_s;
    int   idx_s;

    // Scan from ptr_i upward; the first hit masks every later candidate.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s        = (int'(ptr_i) + k) % NREQ;
            gnt_o[idx_s] = gnt_o[idx_s] | (req_i[idx_s] & ~found_s);
            found_s      = found_s | req_i[idx_s];
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin RAM arbiter with a fixed 2-cycle access and one-cycle ack.
// Optional macro RAM_ARB_PRIORITY_EN gives requester 0 strict priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int AW       = RAM_AW,
    parameter int DW       = RAM_DW,
    parameter int HOLD_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic [DW-1:0]    rdata,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic            cs_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            busy_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   owner_q;
    logic [HW-1:0]   hold_cnt_q;

    logic [PW-1:0]   next_ptr_s;
    logic [PW-1:0]   ptr_s;
    logic [NREQ-1:0] pick_req_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic            pick_vld_s;
    logic            prio_s;
    logic            others_s;
    logic [NREQ-1:0] win_oh_s;
    logic            win_vld_s;
    logic [PW-1:0]   win_idx_s;
    logic [HW-1:0]   hold_d;

    // Search origin: after an ack the pointer moves past the current owner.
    always_comb begin
        next_ptr_s = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);
        ptr_s      = (state_q == ST_ACK) ? next_ptr_s : rr_ptr_q;
`ifdef RAM_ARB_PRIORITY_EN
        prio_s     = req[0];
        pick_req_s = req & ~{{(NREQ-1){1'b0}}, 1'b1};
`else
        prio_s     = 1'b0;
        pick_req_s = req;
`endif
    end

    ram_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_i   (pick_req_s),
        .ptr_i   (ptr_s),
        .gnt_o   (pick_gnt_s),
        .valid_o (pick_vld_s)
    );

    // Winner selection: priority override, then hold rule, then round-robin.
    always_comb begin
        win_oh_s  = pick_gnt_s;
        win_vld_s = pick_vld_s;
        hold_d    = '0;
        others_s  = |(req & ~gnt_q);
        if (prio_s) begin
            win_oh_s  = {{(NREQ-1){1'b0}}, 1'b1};
            win_vld_s = 1'b1;
        end else if ((state_q == ST_ACK) && req[owner_q]) begin
            if (hold_cnt_q != HOLD_LAST) begin
                win_oh_s  = gnt_q;
                win_vld_s = 1'b1;
                hold_d    = hold_cnt_q + HW'(1);
            end else if (!others_s) begin
                // Sole requester keeps the bus; counter stays saturated.
                win_oh_s  = gnt_q;
                win_vld_s = 1'b1;
                hold_d    = hold_cnt_q;
            end else begin
                hold_d = '0;
            end
        end else begin
            hold_d = '0;
        end
    end

    // One-hot winner to index.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_idx_s = win_idx_s | (win_oh_s[i] ? PW'(i) : '0);
        end
    end

    // Access sequencer: IDLE/ACK arbitrate, ACCESS holds cs for one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE, ST_ACK: begin
                    if (state_q == ST_ACK) begin
                        rr_ptr_q <= next_ptr_s;
                    end
                    if (win_vld_s) begin
                        state_q    <= ST_ACCESS;
                        gnt_q      <= win_oh_s;
                        owner_q    <= win_idx_s;
                        cs_q       <= 1'b1;
                        we_q       <= req_we[win_idx_s];
                        addr_q     <= req_addr[int'(win_idx_s)*AW +: AW];
                        wdata_q    <= req_wdata[int'(win_idx_s)*DW +: DW];
                        busy_q     <= 1'b1;
                        hold_cnt_q <= hold_d;
                    end else begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        cs_q       <= 1'b0;
                        we_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        hold_cnt_q <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= ram_rdata;
                    end
                    state_q <= ST_ACK;
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    ack_q   <= gnt_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a HOLD_MAX=4 instance with a RAM model and
// a HOLD_MAX=1 instance for the back-to-back round-robin sequence.
module tb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [47:0] req_addr;
    logic [15:0] req_wdata;

    logic [3:0]  gnt, ack, rdata, ram_wdata, ram_rdata;
    logic        ram_cs, ram_we, busy;
    logic [11:0] ram_addr;

    logic [3:0]  gnt1, ack1, rdata1, ram_wdata1, ram_rdata1;
    logic        ram_cs1, ram_we1, busy1;
    logic [11:0] ram_addr1;

    logic [3:0]  mem [0:4095];
    logic [3:0]  order [5];
    logic [3:0]  exp_hold;
    logic [3:0]  exp_prio;

    int errors = 0;
    int checks = 0;

    ram_arbiter #(.NREQ(4), .AW(12), .DW(4), .HOLD_MAX(4)) u_dut (
        .clock(clock), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
        .rdata(rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    ram_arbiter #(.NREQ(4), .AW(12), .DW(4), .HOLD_MAX(1)) u_dut1 (
        .clock(clock), .reset(reset), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt1), .ack(ack1),
        .rdata(rdata1), .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .busy(busy1)
    );

    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata1 = 4'h0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
`ifdef RAM_ARB_PRIORITY_EN
        order[0] = 4'b0001; order[1] = 4'b0001; order[2] = 4'b0001;
        order[3] = 4'b0001; order[4] = 4'b0001;
        exp_hold = 4'b0001;
        exp_prio = 4'b0001;
`else
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        exp_hold = 4'b1000;
        exp_prio = 4'b0010;
`endif
        reset = 1'b0; req = 4'h0; req_we = 4'h0; req_addr = 48'h0; req_wdata = 16'h0;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_cs", 32'(ram_cs), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // Requester 1 writes 9 to 0x0A5; late input changes must be ignored.
        req_we[1] = 1'b1; req_addr[12 +: 12] = 12'h0A5; req_wdata[4 +: 4] = 4'h9;
        req = 4'b0010;
        tick();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_cs", 32'(ram_cs), 32'h1);
        chk("wr_we", 32'(ram_we), 32'h1);
        chk("wr_addr", 32'(ram_addr), 32'h0A5);
        chk("wr_wdata", 32'(ram_wdata), 32'h9);
        chk("wr_busy", 32'(busy), 32'h1);
        chk("wr_noack", 32'(ack), 32'h0);
        req_addr[12 +: 12] = 12'h3C3; req_wdata[4 +: 4] = 4'h6;
        tick();
        chk("wr_ack", 32'(ack), 32'h2);
        chk("wr_ack_cs", 32'(ram_cs), 32'h0);
        chk("wr_ack_gnt", 32'(gnt), 32'h2);
        chk("wr_mem", 32'(mem[12'h0A5]), 32'h9);
        chk("wr_mem_alt", 32'(mem[12'h3C3]), 32'h0);
        req = 4'h0;
        tick();
        chk("wr_idle_gnt", 32'(gnt), 32'h0);
        chk("wr_idle_ack", 32'(ack), 32'h0);
        chk("wr_idle_busy", 32'(busy), 32'h0);

        // Requester 2 reads back 0x0A5.
        req_we = 4'h0; req_addr[24 +: 12] = 12'h0A5; req = 4'b0100;
        tick();
        chk("rd_gnt", 32'(gnt), 32'h4);
        chk("rd_cs", 32'(ram_cs), 32'h1);
        chk("rd_we", 32'(ram_we), 32'h0);
        chk("rd_addr", 32'(ram_addr), 32'h0A5);
        tick();
        chk("rd_ack", 32'(ack), 32'h4);
        chk("rd_rdata", 32'(rdata), 32'h9);
        chk("rd_we_ack", 32'(ram_we), 32'h0);
        req = 4'h0;
        tick();
        chk("rd_idle", 32'(gnt), 32'h0);

        // Hold rule: req0 held, req3 joins at req0's first ack.
        req_addr[0 +: 12] = 12'h010; req_addr[36 +: 12] = 12'h020; req = 4'b0001;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("hold_gnt", 32'(gnt), 32'h1);
            chk("hold_cs", 32'(ram_cs), 32'h1);
            tick();
            chk("hold_ack", 32'(ack), 32'h1);
            if (n == 0) req[3] = 1'b1;
        end
        tick();
        chk("hold_switch_gnt", 32'(gnt), 32'(exp_hold));
        tick();
        chk("hold_switch_ack", 32'(ack), 32'(exp_hold));
        req = 4'h0;
        tick();
        chk("hold_idle", 32'(gnt), 32'h0);

        // Park rr_ptr at 1, then raise req0 and req1 together.
        req = 4'b0001;
        tick(); tick();
        req = 4'h0;
        tick();
        req = 4'b0011;
        tick();
        chk("prio_gnt", 32'(gnt), 32'(exp_prio));
        tick();
        chk("prio_ack", 32'(ack), 32'(exp_prio));
        req = 4'h0;
        tick();

        // Reset asserted during ACCESS aborts the access.
        req = 4'b0100;
        tick();
        chk("abort_gnt_pre", 32'(gnt), 32'h4);
        chk("abort_cs_pre", 32'(ram_cs), 32'h1);
        reset = 1'b0;
        tick();
        chk("abort_cs", 32'(ram_cs), 32'h0);
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        reset = 1'b1; req = 4'h0;
        tick();
        chk("abort_noack1", 32'(ack), 32'h0);
        tick();
        chk("abort_noack2", 32'(ack), 32'h0);

        // All four held continuously on the HOLD_MAX=1 instance.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(gnt1), 32'(order[k]));
            chk("rr_cs", 32'(ram_cs1), 32'h1);
            chk("rr_noack", 32'(ack1), 32'h0);
            tick();
            chk("rr_ack", 32'(ack1), 32'(order[k]));
            chk("rr_busy", 32'(busy1), 32'h1);
        end
        req = 4'h0;
        tick(); tick();
        chk("rr_idle", 32'(gnt1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
